// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and even-parity helper.
package uart_pkg;

  localparam int UartDataWidth = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  // Bit that makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [UartDataWidth-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: power-of-two depth, drops a push when full unless a pop frees a slot that cycle.
module uart_rx_fifo #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = PtrW + 1;

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : gen_depth_chk
    $error("uart_rx_fifo: Depth must be a power of two and at least 2");
  end

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             wr_en, rd_en;

  assign full  = (level_q == LvlW'(Depth));
  assign empty = (level_q == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Head is forced to zero while empty so the output is clean out of reset.
  assign rdata = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a valid/ready FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int FifoDepth      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     uart_rx_i,
  output logic [UartDataWidth-1:0] rx_data_o,
  output logic                     rx_valid_o,
  input  logic                     rx_ready_i,
  output logic                     frame_err_o,
  output logic                     overrun_o,
  output logic                     parity_err_o
);

  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int CntW       = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(ClksPerBit - 1);

  if (ClksPerBit < 8) begin : gen_clks_chk
    $error("uart_rx: ClockFrequency / BaudRate must be at least 8");
  end

  logic                     sync_p0, rx_s;
  uart_rx_state_e           state_q, state_d;
  logic [CntW-1:0]          cnt_q;
  logic [2:0]               bit_idx_q;
  logic [UartDataWidth-1:0] shift_q;
  logic                     par_bad;
  logic                     sample;
  logic                     cnt_load, bit_clr, shift_en, push;
  logic                     frame_set, parity_set;
  logic [CntW-1:0]          cnt_load_val;
  logic                     fifo_full, fifo_empty, pop;
  logic                     frame_err_q, overrun_q, parity_err_q;
`ifdef UART_RX_PARITY_EN
  logic                     par_chk;
`endif

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_p0 <= uart_rx_i;
      rx_s    <= sync_p0;
    end
  end

  assign sample = (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rx_s) state_d = START;
      START:  if (sample) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (sample && bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (sample) state_d = STOP;
      STOP:   if (sample) state_d = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = CntFull;
    bit_clr      = 1'b0;
    shift_en     = 1'b0;
    push         = 1'b0;
    frame_set    = 1'b0;
    parity_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_load     = !rx_s;
        cnt_load_val = CntHalf;
      end
      START: begin
        cnt_load = sample && !rx_s;
        bit_clr  = sample && !rx_s;
      end
      DATA: begin
        cnt_load = sample;
        shift_en = sample;
      end
      PARITY: begin
        cnt_load = sample;
`ifdef UART_RX_PARITY_EN
        par_chk  = sample;
`endif
      end
      STOP: begin
        // A bad stop bit masks any parity result.
        if (sample) begin
          if (!rx_s)        frame_set  = 1'b1;
          else if (par_bad) parity_set = 1'b1;
          else              push       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
    end else begin
      if (cnt_load)         cnt_q <= cnt_load_val;
      else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (bit_clr)          bit_idx_q <= '0;
      else if (shift_en)    bit_idx_q <= bit_idx_q + 1'b1;
    end
  end

  // LSB arrives first, so new bits enter at the top and shift down.
  always_ff @(posedge clk_i) begin
    if (shift_en) shift_q <= {rx_s, shift_q[UartDataWidth-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      par_bad <= 1'b0;
    else if (bit_clr) par_bad <= 1'b0;
    else if (par_chk) par_bad <= (rx_s != even_parity(shift_q));
  end
`else
  assign par_bad = 1'b0;
`endif

  assign pop = rx_valid_o && rx_ready_i;

  uart_rx_fifo #(
    .Depth (FifoDepth),
    .Width (UartDataWidth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (shift_q),
    .pop    (pop),
    .rdata  (rx_data_o),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign rx_valid_o = !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= frame_set;
      overrun_q    <= push && fifo_full && !pop;
      parity_err_q <= parity_set;
    end
  end

  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign parity_err_o = parity_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected events, a monitor pops and compares.
module tb_uart_rx;

  localparam int ClkFreq = 1_600_000;
  localparam int Baud    = 100_000;
  localparam int Depth   = 4;
  localparam int BitClks = 16;
`ifdef UART_RX_PARITY_EN
  localparam int ParExtra = 16;
`else
  localparam int ParExtra = 0;
`endif

  localparam logic [1:0] K_BYTE  = 2'd0;
  localparam logic [1:0] K_FRAME = 2'd1;
  localparam logic [1:0] K_OVR   = 2'd2;
  localparam logic [1:0] K_PAR   = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       uart_rx_i = 1'b1;
  logic       rx_ready_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, frame_err_o, overrun_o, parity_err_o;

  evt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .ClockFrequency (ClkFreq),
    .BaudRate       (Baud),
    .FifoDepth      (Depth)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .uart_rx_i    (uart_rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o)
  );

  function automatic string kind_name(input logic [1:0] k);
    case (k)
      K_BYTE:  return "byte";
      K_FRAME: return "frame_err";
      K_OVR:   return "overrun";
      default: return "parity_err";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input logic [1:0] kind, input logic [7:0] data);
    evt_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic got_evt(input logic [1:0] kind, input logic [7:0] data);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got %s data 0x%0h, expected no output", kind_name(kind),
               kind_name(kind), data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_BYTE && e.data != data)) begin
        errors++;
        $display("FAIL event_order: got %s data 0x%0h, expected %s data 0x%0h",
                 kind_name(kind), data, kind_name(e.kind), e.data);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      #1;
      if (rst_ni) begin
        if (rx_valid_o && rx_ready_i) got_evt(K_BYTE, rx_data_o);
        if (frame_err_o)  got_evt(K_FRAME, 8'h00);
        if (overrun_o)    got_evt(K_OVR, 8'h00);
        if (parity_err_o) got_evt(K_PAR, 8'h00);
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; drives one frame, leaving the line at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    uart_rx_i = 1'b0;
    wait_cycles(BitClks);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = d[i];
      wait_cycles(BitClks);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx_i = p;
    wait_cycles(BitClks);
`endif
    uart_rx_i = stop;
    wait_cycles(BitClks);
  endtask

  task automatic run_tests();
    int n;
    // Reset state
    wait_cycles(3);
    check("reset_rx_data", rx_data_o, 8'h00);
    check("reset_rx_valid", rx_valid_o, 0);
    check("reset_frame_err", frame_err_o, 0);
    check("reset_overrun", overrun_o, 0);
    check("reset_parity_err", parity_err_o, 0);
    rst_ni = 1'b1;
    wait_cycles(5);

    // Single frame with consumer stalled; latency from pin fall to valid
    rx_ready_i = 1'b0;
    expect_evt(K_BYTE, 8'hA5);
    fork
      send_frame(8'hA5, ^8'hA5, 1'b1);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!rx_valid_o && n < 400);
        checks++;
        if (n < 152 + ParExtra || n > 156 + ParExtra) begin
          errors++;
          $display("FAIL a5_latency: got %0d cycles, expected %0d..%0d", n, 152 + ParExtra,
                   156 + ParExtra);
        end
        check("a5_head_data", rx_data_o, 8'hA5);
      end
    join
    wait_cycles(10);
    rx_ready_i = 1'b1;
    wait_cycles(5);
    check("a5_drained", rx_valid_o, 0);

    // Glitch rejection then a good byte
    uart_rx_i = 1'b0;
    wait_cycles(4);
    uart_rx_i = 1'b1;
    wait_cycles(30);
    expect_evt(K_BYTE, 8'h3C);
    send_frame(8'h3C, ^8'h3C, 1'b1);
    wait_cycles(20);

    // Framing error followed by a held-low line
    expect_evt(K_FRAME, 8'h00);
    send_frame(8'h55, ^8'h55, 1'b0);
    wait_cycles(40);
    uart_rx_i = 1'b1;
    wait_cycles(40);

    // Overrun on the fifth back-to-back byte
    rx_ready_i = 1'b0;
    expect_evt(K_OVR, 8'h00);
    for (int i = 1; i <= 4; i++) expect_evt(K_BYTE, 8'(i));
    for (int i = 1; i <= 5; i++) send_frame(8'(i), ^(8'(i)), 1'b1);
    wait_cycles(20);
    rx_ready_i = 1'b1;
    check("ovr_valid_pop0", rx_valid_o, 1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("ovr_valid_consecutive", rx_valid_o, 1);
    end
    @(negedge clk);
    check("ovr_valid_after_drain", rx_valid_o, 0);
    rx_ready_i = 1'b0;
    wait_cycles(5);

    // Pop in the same cycle as the push into a full FIFO
    for (int i = 1; i <= 5; i++) expect_evt(K_BYTE, 8'(8'h10 + i));
    for (int i = 1; i <= 4; i++) send_frame(8'(8'h10 + i), ^(8'(8'h10 + i)), 1'b1);
    fork
      send_frame(8'h15, ^8'h15, 1'b1);
      begin
        repeat (154 + ParExtra) @(posedge clk);
        @(negedge clk);
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
      end
    join
    wait_cycles(20);
    check("popfull_level_valid", rx_valid_o, 1);
    rx_ready_i = 1'b1;
    wait_cycles(10);
    check("popfull_drained", rx_valid_o, 0);

`ifdef UART_RX_PARITY_EN
    // Parity error drops the byte; correct parity delivers it
    expect_evt(K_PAR, 8'h00);
    send_frame(8'h03, 1'b1, 1'b1);
    wait_cycles(10);
    expect_evt(K_BYTE, 8'h03);
    send_frame(8'h03, 1'b0, 1'b1);
    wait_cycles(20);
`endif

    // Reset in the middle of a frame, then recovery
    uart_rx_i = 1'b0;
    wait_cycles(BitClks);
    uart_rx_i = 1'b1;
    wait_cycles(BitClks);
    uart_rx_i = 1'b0;
    wait_cycles(BitClks);
    rst_ni = 1'b0;
    uart_rx_i = 1'b1;
    wait_cycles(2);
    check("midreset_valid", rx_valid_o, 0);
    check("midreset_data", rx_data_o, 8'h00);
    rst_ni = 1'b1;
    wait_cycles(200);
    expect_evt(K_BYTE, 8'h7E);
    send_frame(8'h7E, ^8'h7E, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      run_tests();
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
